eth_tx_arbiter: RTL
===================

Name: eth_tx_arbiter

Overview:
Shares the single MII transmit byte stream between the ARP sender and the UDP sender. Latches send requests, grants one sender at a time via a one-cycle enable pulse, and muxes the granted sender's tx_data/tx_en onto the PHY. Enforces the inter-frame gap and guards against stuck or absent senders. Sits between eth_send / udp_packet and the o_tx_data / o_tx_en top-level pins, in the i_tx_clk domain.

Parameters:
IFG_CYCLES, 12, idle byte-times forced after every frame's tx_en falls (min 1)
START_TIMEOUT, 64, cycles allowed from enable pulse to first tx_en of the granted sender
MAX_FRAME_CYCLES, 1530, maximum consecutive tx_en cycles before forced abort
CNT_W, 16, width of the frame counter

Ports:
clk  in  1  transmit byte clock (i_tx_clk at top)
rst_n  in  1  asynchronous active-low reset
i_arp_req  in  1  one-cycle ARP send request
i_udp_req  in  1  one-cycle UDP send request
o_arp_enable  out  1  one-cycle start pulse to ARP sender i_enable
o_udp_enable  out  1  one-cycle start pulse to UDP sender i_enable
i_arp_tx_data  in  8  ARP sender byte
i_arp_tx_en  in  1  ARP sender byte valid
i_udp_tx_data  in  8  UDP sender byte
i_udp_tx_en  in  1  UDP sender byte valid
o_tx_data  out  8  byte to PHY, registered
o_tx_en  out  1  valid to PHY, registered
o_busy  out  1  high in any state except IDLE
o_arp_done  out  1  one-cycle pulse, ARP frame finished
o_udp_done  out  1  one-cycle pulse, UDP frame finished
o_timeout  out  1  one-cycle pulse on start timeout or max-frame abort
o_frame_count  out  CNT_W  completed frames, wraps at 2^CNT_W

Behaviour:
- Reset: all outputs 0, state IDLE, both pending bits 0, last-grant = UDP (so ARP wins first tie), counters 0.
- Pending: req sets its pending bit; repeated req while pending merges (no queueing). Request arriving in the same cycle its pending bit is cleared re-sets it (set wins).
- IDLE: if any pending, select: single pending -> that one; both -> opposite of last-grant (round-robin). Same cycle: clear selected pending, update last-grant, go START. No grant while nothing is pending.
- START: enable pulse for selected sender is high for exactly the first START cycle (1 cycle after IDLE decision). Wait for selected tx_en=1 -> SEND. After START_TIMEOUT cycles without it -> o_timeout pulse, go IFG.
- SEND: o_tx_data/o_tx_en <= selected inputs (1-cycle latency, no gaps inserted); non-selected sender's inputs ignored entirely. On selected tx_en=0: done pulse for that sender, o_frame_count +1, go IFG. If tx_en high for MAX_FRAME_CYCLES consecutive cycles: o_tx_en forced 0 next cycle, o_timeout pulse, no done, no count, go DRAIN.
- DRAIN: o_tx_en held 0; wait for selected tx_en=0, then IFG.
- IFG: o_tx_en=0, o_tx_data=0; down-counter loaded with IFG_CYCLES on entry; IDLE when it reaches 0. Requests keep latching during every state.
- o_tx_en=0 and o_tx_data=0 in every state other than SEND.
- Reset mid-frame: o_tx_en drops asynchronously; pending requests lost.

Decomposition:
- Package eth_tx_pkg: typedef enum {IDLE, START, SEND, DRAIN, IFG} tx_arb_state_t; typedef enum logic {SRC_ARP, SRC_UDP} tx_src_t.
- No sub-module; single always_ff FSM plus output mux register.

Test Plan:
- Single UDP req, sender emits 70 bytes 0x00..0x45 -> o_udp_enable pulse 1 cycle after req; identical 70 bytes on o_tx_data 1 cycle delayed; o_udp_done once; o_frame_count=1; o_tx_en low ≥12 cycles after.
- ARP and UDP req same cycle after reset -> ARP granted first, UDP enable issued exactly 12 idle cycles after ARP tx_en falls; count=2.
- Three UDP reqs during an ARP frame -> exactly one UDP frame follows (merge); UDP tx_en glitches during ARP frame never reach o_tx_en.
- UDP granted, sender never asserts tx_en -> o_timeout at cycle 64 after enable, IFG, then pending ARP granted.
- UDP tx_en stuck high -> o_tx_en drops after 1530 cycles, o_timeout pulse, count unchanged, IDLE only after tx_en released plus 12 cycles.
- rst_n low mid-SEND -> o_tx_en=0 immediately; after release no enable pulses without new req.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared types for the Ethernet transmit arbiter: FSM states, sender
// identifiers and the round-robin selection rule.
package eth_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SEND,
    DRAIN,
    IFG
  } tx_arb_state_t;

  typedef enum logic {
    SRC_ARP,
    SRC_UDP
  } tx_src_t;

  // Pick the next sender: a lone requester wins outright, a tie goes to
  // whichever sender was not granted last.
  function automatic tx_src_t pick_src(input logic arp_pend, input logic udp_pend,
                                       input tx_src_t last);
    if (arp_pend && udp_pend) begin
      return (last == SRC_ARP) ? SRC_UDP : SRC_ARP;
    end else if (arp_pend) begin
      return SRC_ARP;
    end else begin
      return SRC_UDP;
    end
  endfunction

endpackage

// File: rtl/eth_tx_arbiter.sv
// Shares the MII transmit byte stream between the ARP and UDP senders.
// Latches requests, grants one sender per frame with a start pulse,
// forwards its bytes with one cycle of latency, enforces the inter-frame
// gap and recovers from senders that never start or never stop.
module eth_tx_arbiter
  import eth_tx_pkg::*;
#(
  parameter int IFG_CYCLES       = 12,
  parameter int START_TIMEOUT    = 64,
  parameter int MAX_FRAME_CYCLES = 1530,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_arp_req,
  input  logic             i_udp_req,
  output logic             o_arp_enable,
  output logic             o_udp_enable,
  input  logic [7:0]       i_arp_tx_data,
  input  logic             i_arp_tx_en,
  input  logic [7:0]       i_udp_tx_data,
  input  logic             i_udp_tx_en,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_en,
  output logic             o_busy,
  output logic             o_arp_done,
  output logic             o_udp_done,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_frame_count
);

  // One shared timer serves the start timeout, the frame length limit and
  // the inter-frame gap, so it is sized for the largest of the three.
  localparam int TMR_MAX =
    (MAX_FRAME_CYCLES > START_TIMEOUT)
      ? ((MAX_FRAME_CYCLES > IFG_CYCLES) ? MAX_FRAME_CYCLES : IFG_CYCLES)
      : ((START_TIMEOUT > IFG_CYCLES) ? START_TIMEOUT : IFG_CYCLES);
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  typedef logic [TMR_W-1:0] tmr_t;

  tx_arb_state_t state;
  tx_src_t       src;        // current grant, doubles as last-grant for round-robin
  logic          arp_pend;
  logic          udp_pend;
  tmr_t          timer;

  logic          sel_tx_en;
  logic [7:0]    sel_tx_data;
  logic          grant;
  tx_src_t       next_src;
  logic          grant_arp;
  logic          grant_udp;

  // Granted-sender mux and the IDLE grant decision
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, otherwise
    // synthesis infers a latch to hold the old value.
    sel_tx_en   = (src == SRC_ARP) ? i_arp_tx_en : i_udp_tx_en;
    sel_tx_data = (src == SRC_ARP) ? i_arp_tx_data : i_udp_tx_data;
    grant       = (state == IDLE) && (arp_pend || udp_pend);
    next_src    = pick_src(arp_pend, udp_pend, src);
    grant_arp   = grant && (next_src == SRC_ARP);
    grant_udp   = grant && (next_src == SRC_UDP);
  end

  // Request latches: a request in the cycle its bit is consumed survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arp_pend <= 1'b0;
      udp_pend <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments in clocked logic so every register
      // samples pre-edge values regardless of statement order.
      arp_pend <= i_arp_req | (arp_pend & ~grant_arp);
      udp_pend <= i_udp_req | (udp_pend & ~grant_udp);
    end
  end

  // Arbitration FSM with registered pulses and PHY outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      src           <= SRC_UDP;
      timer         <= '0;
      o_arp_enable  <= 1'b0;
      o_udp_enable  <= 1'b0;
      o_arp_done    <= 1'b0;
      o_udp_done    <= 1'b0;
      o_timeout     <= 1'b0;
      o_tx_en       <= 1'b0;
      o_tx_data     <= 8'h00;
      o_frame_count <= '0;
    end else begin
      // Pulses and the PHY bus idle low unless a state below drives them.
      o_arp_enable <= 1'b0;
      o_udp_enable <= 1'b0;
      o_arp_done   <= 1'b0;
      o_udp_done   <= 1'b0;
      o_timeout    <= 1'b0;
      o_tx_en      <= 1'b0;
      o_tx_data    <= 8'h00;

      case (state)
        IDLE: begin
          if (grant) begin
            src          <= next_src;
            o_arp_enable <= grant_arp;
            o_udp_enable <= grant_udp;
            timer        <= '0;
            state        <= START;
          end
        end

        START: begin
          // The first valid byte is forwarded here so none is lost.
          if (sel_tx_en) begin
            o_tx_en   <= 1'b1;
            o_tx_data <= sel_tx_data;
            timer     <= tmr_t'(1);
            state     <= SEND;
          end else if (timer == tmr_t'(START_TIMEOUT - 1)) begin
            o_timeout <= 1'b1;
            timer     <= tmr_t'(IFG_CYCLES);
            state     <= IFG;
          end else begin
            timer <= timer + tmr_t'(1);
          end
        end

        SEND: begin
          // timer counts bytes already forwarded in this frame.
          if (!sel_tx_en) begin
            o_arp_done    <= (src == SRC_ARP);
            o_udp_done    <= (src == SRC_UDP);
            o_frame_count <= o_frame_count + CNT_W'(1);
            timer         <= tmr_t'(IFG_CYCLES);
            state         <= IFG;
          end else if (timer == tmr_t'(MAX_FRAME_CYCLES)) begin
            o_timeout <= 1'b1;
            state     <= DRAIN;
          end else begin
            o_tx_en   <= 1'b1;
            o_tx_data <= sel_tx_data;
            timer     <= timer + tmr_t'(1);
          end
        end

        DRAIN: begin
          if (!sel_tx_en) begin
            timer <= tmr_t'(IFG_CYCLES);
            state <= IFG;
          end
        end

        IFG: begin
          timer <= timer - tmr_t'(1);
          if (timer <= tmr_t'(1)) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy = (state != IDLE);

endmodule
